// File: rtl/grid_cursor_controller_if.sv
// Button inputs and cursor/board outputs of grid_cursor_controller.
// The DUT side uses the slave modport; whoever drives the buttons uses master.
interface grid_cursor_controller_if #(
    parameter int unsigned COLS = 3,
    parameter int unsigned ROWS = 3
);
    localparam int unsigned N     = COLS * ROWS;
    localparam int unsigned POS_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(N + 1);

    logic             btn_next;
    logic             btn_place;
    logic             clear;
    logic [15:0]      selected_square_startX;
    logic [15:0]      selected_square_endX;
    logic [9:0]       selected_square_startY;
    logic [9:0]       selected_square_endY;
    logic [POS_W-1:0] position;
    logic             playX;
    logic             playO;
    logic             place_reject;
    logic             turn_o;
    logic [2*N-1:0]   board;
    logic             board_full;
    logic [CNT_W-1:0] turn_count;

    modport master (
        output btn_next, btn_place, clear,
        input  selected_square_startX, selected_square_endX,
        input  selected_square_startY, selected_square_endY,
        input  position, playX, playO, place_reject, turn_o, board, board_full, turn_count
    );

    modport slave (
        input  btn_next, btn_place, clear,
        output selected_square_startX, selected_square_endX,
        output selected_square_startY, selected_square_endY,
        output position, playX, playO, place_reject, turn_o, board, board_full, turn_count
    );
endinterface

// File: rtl/grid_cursor_controller.sv
// Debounced two-button cursor/placement controller over a COLS x ROWS grid,
// with X/O turn tracking and a registered pixel rectangle for the cursor cell.
module grid_cursor_controller #(
    parameter int unsigned COLS            = 3,
    parameter int unsigned ROWS            = 3,
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                    Clk,
    input logic                    rst,
    grid_cursor_controller_if.slave bus
);
    localparam int unsigned N      = COLS * ROWS;
    localparam int unsigned POS_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W  = $clog2(N + 1);
    localparam int unsigned CELL_W = SCREEN_W / COLS;
    localparam int unsigned CELL_H = SCREEN_H / ROWS;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    // Button lanes: bit 0 = next, bit 1 = place.
    logic [1:0]      raw;
    logic [1:0]      sync0_q, sync1_q, lvl_q, lvl_prev_q, ev_q;
    logic [DB_W-1:0] cnt_q [2];

    assign raw = {bus.btn_place, bus.btn_next};

    always_ff @(posedge Clk) begin
        if (!rst) begin
            sync0_q    <= '0;
            sync1_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            ev_q       <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
        end else begin
            sync0_q    <= raw;
            sync1_q    <= sync0_q;
            lvl_prev_q <= lvl_q;
            ev_q       <= lvl_q & ~lvl_prev_q;
            for (int b = 0; b < 2; b++) begin
                if (sync1_q[b] == lvl_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_q[b] <= ~lvl_q[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    logic [POS_W-1:0] position_q, position_d;
    logic [2*N-1:0]   board_q, board_d;
    logic             turn_q, turn_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             play_x_q, play_x_d, play_o_q, play_o_d, reject_q, reject_d;
    logic [1:0]       cur_cell;
    logic             full;

    assign full = (count_q == CNT_W'(N));

    always_comb begin
        cur_cell = 2'b00;
        for (int i = 0; i < int'(N); i++) begin
            if (position_q == POS_W'(i)) cur_cell = board_q[2*i +: 2];
        end
    end

    // Place reads the pre-move position; a same-cycle next still advances.
    always_comb begin
        position_d = position_q;
        board_d    = board_q;
        turn_d     = turn_q;
        count_d    = count_q;
        play_x_d   = 1'b0;
        play_o_d   = 1'b0;
        reject_d   = 1'b0;
        if (bus.clear) begin
            position_d = '0;
            board_d    = '0;
            turn_d     = 1'b0;
            count_d    = '0;
        end else begin
            if (ev_q[1]) begin
                if (cur_cell == 2'b00 && !full) begin
                    for (int i = 0; i < int'(N); i++) begin
                        if (position_q == POS_W'(i)) board_d[2*i +: 2] = turn_q ? 2'b10 : 2'b01;
                    end
                    play_x_d = ~turn_q;
                    play_o_d = turn_q;
                    turn_d   = ~turn_q;
                    count_d  = count_q + CNT_W'(1);
                end else begin
                    reject_d = 1'b1;
                end
            end
            if (ev_q[0]) begin
                position_d = (position_q == POS_W'(N - 1)) ? '0 : position_q + POS_W'(1);
            end
        end
    end

    logic [15:0]  start_x_q, start_x_d, end_x_q, end_x_d;
    logic [9:0]   start_y_q, start_y_d, end_y_q, end_y_d;
    int unsigned  col, row;

    // Last column/row stretches to the screen edge to absorb the remainder.
    always_comb begin
        col       = int'(position_q) % COLS;
        row       = int'(position_q) / COLS;
        start_x_d = 16'(col * CELL_W);
        end_x_d   = (col == COLS - 1) ? 16'(SCREEN_W) : 16'((col + 1) * CELL_W);
        start_y_d = 10'(row * CELL_H);
        end_y_d   = (row == ROWS - 1) ? 10'(SCREEN_H) : 10'((row + 1) * CELL_H);
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            position_q <= '0;
            board_q    <= '0;
            turn_q     <= 1'b0;
            count_q    <= '0;
            play_x_q   <= 1'b0;
            play_o_q   <= 1'b0;
            reject_q   <= 1'b0;
            start_x_q  <= '0;
            end_x_q    <= 16'(CELL_W);
            start_y_q  <= '0;
            end_y_q    <= 10'(CELL_H);
        end else begin
            position_q <= position_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            count_q    <= count_d;
            play_x_q   <= play_x_d;
            play_o_q   <= play_o_d;
            reject_q   <= reject_d;
            start_x_q  <= start_x_d;
            end_x_q    <= end_x_d;
            start_y_q  <= start_y_d;
            end_y_q    <= end_y_d;
        end
    end

    assign bus.position               = position_q;
    assign bus.board                  = board_q;
    assign bus.turn_o                 = turn_q;
    assign bus.turn_count             = count_q;
    assign bus.board_full             = full;
    assign bus.playX                  = play_x_q;
    assign bus.playO                  = play_o_q;
    assign bus.place_reject           = reject_q;
    assign bus.selected_square_startX = start_x_q;
    assign bus.selected_square_endX   = end_x_q;
    assign bus.selected_square_startY = start_y_q;
    assign bus.selected_square_endY   = end_y_q;
endmodule

// File: tb/tb_grid_cursor_controller.sv
// Self-checking bench: a 3x3 instance checked through an event scoreboard and
// a vector table, and a 2x2 instance for the full-board and clear sequence.
module tb_grid_cursor_controller;
    localparam int unsigned D = 4;

    logic Clk = 1'b0;
    logic rst;
    always #5 Clk = ~Clk;

    grid_cursor_controller_if #(.COLS(3), .ROWS(3)) ifa ();
    grid_cursor_controller_if #(.COLS(2), .ROWS(2)) ifb ();

    grid_cursor_controller #(
        .COLS(3), .ROWS(3), .SCREEN_W(640), .SCREEN_H(480), .DEBOUNCE_CYCLES(D)
    ) dut_a (
        .Clk(Clk), .rst(rst), .bus(ifa)
    );

    grid_cursor_controller #(
        .COLS(2), .ROWS(2), .SCREEN_W(640), .SCREEN_H(480), .DEBOUNCE_CYCLES(D)
    ) dut_b (
        .Clk(Clk), .rst(rst), .bus(ifb)
    );

    typedef struct packed {
        logic [3:0]  pos;
        logic        px;
        logic        po;
        logic        rej;
        logic        turn;
        logic [3:0]  cnt;
        logic [17:0] board;
    } obs_t;

    typedef struct {
        logic nxt;
        logic plc;
        obs_t exp;
    } vec_t;

    int   comps = 0;
    int   fails = 0;
    obs_t sb_q[$];
    bit   mon_en = 1'b0;
    int   bx = 0, bo = 0, brej = 0;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        comps++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic n, input logic p, input int pos, input logic px,
                                input logic po, input logic rej, input logic turn,
                                input int cnt, input logic [17:0] board);
        vec_t v;
        v.nxt = n;
        v.plc = p;
        v.exp = {4'(pos), px, po, rej, turn, 4'(cnt), board};
        return v;
    endfunction

    function automatic obs_t obs_a();
        return {ifa.position, ifa.playX, ifa.playO, ifa.place_reject, ifa.turn_o,
                ifa.turn_count, ifa.board};
    endfunction

    // Independent model of the 3x3 / 640x480 cell rectangles.
    function automatic logic [51:0] rect_of(input int unsigned p);
        int unsigned c, r;
        c = p % 3;
        r = p / 3;
        return {16'(c * 213), 16'((c == 2) ? 640 : (c + 1) * 213),
                10'(r * 160), 10'((r == 2) ? 480 : (r + 1) * 160)};
    endfunction

    function automatic logic [51:0] rect_a();
        return {ifa.selected_square_startX, ifa.selected_square_endX,
                ifa.selected_square_startY, ifa.selected_square_endY};
    endfunction

    function automatic logic [51:0] rect_b();
        return {ifb.selected_square_startX, ifb.selected_square_endX,
                ifb.selected_square_startY, ifb.selected_square_endY};
    endfunction

    // Scoreboard monitor: every pulse or cursor move on dut_a pops one expectation.
    logic [3:0] prev_pos = '0;
    logic [3:0] lag_pos = '0;
    bit         lag_pend = 1'b0;
    obs_t       cur, exp_o;
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (lag_pend) chk("rect_lag", 64'(rect_a()), 64'(rect_of(int'(lag_pos))));
                lag_pend = 1'b0;
                cur = obs_a();
                if (cur.pos != prev_pos || cur.px || cur.po || cur.rej) begin
                    if (sb_q.size() == 0) begin
                        comps++;
                        fails++;
                        $display("FAIL unexpected_event: actual %0h required none", cur);
                    end else begin
                        exp_o = sb_q.pop_front();
                        chk("sb_event", 64'(cur), 64'(exp_o));
                    end
                    if (cur.pos != prev_pos) begin
                        chk("rect_hold", 64'(rect_a()), 64'(rect_of(int'(prev_pos))));
                        lag_pend = 1'b1;
                        lag_pos  = cur.pos;
                    end
                end
            end else begin
                lag_pend = 1'b0;
            end
            prev_pos = ifa.position;
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (ifb.playX) bx++;
            if (ifb.playO) bo++;
            if (ifb.place_reject) brej++;
        end
    end

    task automatic press(input bit on_b, input logic n, input logic p);
        @(posedge Clk);
        #1;
        if (on_b) begin
            ifb.btn_next = n;
            ifb.btn_place = p;
        end else begin
            ifa.btn_next = n;
            ifa.btn_place = p;
        end
        repeat (D + 6) @(posedge Clk);
        #1;
        ifa.btn_next = 1'b0;
        ifa.btn_place = 1'b0;
        ifb.btn_next = 1'b0;
        ifb.btn_place = 1'b0;
        repeat (D + 6) @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    // Edges counted from the first sampling edge of a held btn_next on dut_a.
    task automatic measure_next(output int n);
        n = 0;
        while (ifa.position == 4'd0 && n < 40) begin
            @(posedge Clk);
            n++;
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    logic [7:0] b_board[4];
    int         lat;

    initial begin
        b_board = '{8'h01, 8'h09, 8'h19, 8'h99};
        for (int i = 0; i < 8; i++) vecs[i] = mk(1, 0, (i + 2) % 9, 0, 0, 0, 0, 0, 18'h0);
        vecs[8]  = mk(0, 1, 0, 1, 0, 0, 1, 1, 18'h01);
        vecs[9]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 18'h01);
        vecs[10] = mk(1, 0, 1, 0, 0, 0, 1, 1, 18'h01);
        vecs[11] = mk(0, 1, 1, 0, 1, 0, 0, 2, 18'h09);
        vecs[12] = mk(1, 0, 2, 0, 0, 0, 0, 2, 18'h09);
        vecs[13] = mk(1, 0, 3, 0, 0, 0, 0, 2, 18'h09);
        vecs[14] = mk(1, 1, 4, 1, 0, 0, 1, 3, 18'h49);

        rst = 1'b0;
        ifa.btn_next = 1'b0;
        ifa.btn_place = 1'b0;
        ifa.clear = 1'b0;
        ifb.btn_next = 1'b0;
        ifb.btn_place = 1'b0;
        ifb.clear = 1'b0;
        repeat (2) @(posedge Clk);
        #1 rst = 1'b1;
        @(negedge Clk);
        chk("reset_a_state", 64'({obs_a(), ifa.board_full}), 64'd0);
        chk("reset_a_rect", 64'(rect_a()), 64'({16'd0, 16'd213, 10'd0, 10'd160}));
        chk("reset_b_rect", 64'(rect_b()), 64'({16'd0, 16'd320, 10'd0, 10'd240}));

        // 2x2 board: fill every cell, then a refused place, then clear.
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0, 1'b1);
            chk("b_fill", 64'({ifb.position, ifb.turn_o, ifb.turn_count, ifb.board_full, ifb.board}),
                64'({2'(i), (i % 2 == 0), 3'(i + 1), (i == 3), b_board[i]}));
            if (i < 3) press(1'b1, 1'b1, 1'b0);
            if (i == 0) chk("b_rect_cell1", 64'(rect_b()),
                            64'({16'd320, 16'd640, 10'd0, 10'd240}));
        end
        press(1'b1, 1'b0, 1'b1);
        chk("b_full_reject", 64'({brej[7:0], bx[7:0], bo[7:0], ifb.turn_count, ifb.board}),
            64'({8'd1, 8'd2, 8'd2, 3'd4, 8'h99}));
        @(posedge Clk);
        #1 ifb.clear = 1'b1;
        @(posedge Clk);
        #1 ifb.clear = 1'b0;
        @(negedge Clk);
        chk("b_clear", 64'({ifb.position, ifb.turn_o, ifb.turn_count, ifb.board_full, ifb.board}),
            64'd0);
        @(negedge Clk);
        chk("b_clear_rect", 64'(rect_b()), 64'({16'd0, 16'd320, 10'd0, 10'd240}));

        // 3x3: a 3-cycle glitch must not move the cursor.
        @(posedge Clk);
        #1 mon_en = 1'b1;
        ifa.btn_next = 1'b1;
        repeat (3) @(posedge Clk);
        #1 ifa.btn_next = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        chk("glitch_no_move", 64'(ifa.position), 64'd0);

        // Held press: one move, D+4 edges after the first sampling edge.
        sb_q.push_back({4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 18'h0});
        @(posedge Clk);
        #1 ifa.btn_next = 1'b1;
        measure_next(lat);
        chk("next_latency", 64'(lat), 64'(D + 4));
        repeat (20 - lat) @(posedge Clk);
        #1 ifa.btn_next = 1'b0;
        repeat (15) @(posedge Clk);
        drain();

        for (int i = 0; i < 15; i++) begin
            sb_q.push_back(vecs[i].exp);
            press(1'b0, vecs[i].nxt, vecs[i].plc);
            drain();
            if (vecs[i].exp.pos == 4'd5)
                chk("rect_cell5", 64'(rect_a()), 64'({16'd426, 16'd640, 10'd160, 10'd320}));
        end

        // Reset mid-game while btn_next is mid-debounce.
        @(posedge Clk);
        #1 ifa.btn_next = 1'b1;
        repeat (3) @(posedge Clk);
        #1 mon_en = 1'b0;
        rst = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_mid_state", 64'({obs_a(), ifa.board_full}), 64'd0);
        chk("rst_mid_rect", 64'(rect_a()), 64'({16'd0, 16'd213, 10'd0, 10'd160}));
        rst = 1'b1;
        sb_q.push_back({4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 18'h0});
        #1 mon_en = 1'b1;
        measure_next(lat);
        chk("rst_redebounce_latency", 64'(lat), 64'(D + 4));
        repeat (10) @(posedge Clk);
        #1 ifa.btn_next = 1'b0;
        repeat (15) @(posedge Clk);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end
endmodule
